// File: rtl/fire7_pkg.sv
// Shared constants and types for the fire7 expand1 output feature-map writer.
package fire7_pkg;

    localparam int WIDTH  = 16;
    localparam int DSP_NO = 192;
    localparam int WOUT   = 16;
    localparam int BANKS  = 4;
    localparam int BEATS  = DSP_NO / BANKS;
    localparam int NPIX   = WOUT * WOUT;
    localparam int ADDR_W = $clog2(BEATS * NPIX);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int PIX_W  = $clog2(NPIX);
    localparam int CH_W   = $clog2(DSP_NO);

    typedef logic [WIDTH-1:0] act_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } wr_state_t;

endpackage

// File: rtl/fire7_expand1_ofm_writer_if.sv
// Sample input from the MAC array and the banked RAM write port of the OFM writer.
interface fire7_expand1_ofm_writer_if;
    import fire7_pkg::*;

    logic                sample_i;
    act_t                ofm_i [DSP_NO];
    logic [BANKS-1:0]    ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    act_t                ram_din [BANKS];
    logic                ram_feedback;
    logic                busy;
    logic                overrun_err;

    // The writer masters the RAM port and consumes the channel vector.
    modport master (
        input  sample_i, ofm_i,
        output ram_we, ram_addr, ram_din, ram_feedback, busy, overrun_err
    );

    modport slave (
        output sample_i, ofm_i,
        input  ram_we, ram_addr, ram_din, ram_feedback, busy, overrun_err
    );

endinterface

// File: rtl/fire7_expand1_ofm_writer.sv
// Captures one 192-channel output pixel per sample pulse and drains it into
// BANKS RAM banks over BEATS cycles; pulses ram_feedback after the last pixel.
module fire7_expand1_ofm_writer
    import fire7_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    fire7_expand1_ofm_writer_if.master    bus
);

    if (DSP_NO % BANKS != 0) begin : g_cfg_check
        $error("DSP_NO must be a multiple of BANKS");
    end

    wr_state_t           state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic                overrun_q, overrun_d;
    logic                ram_feedback_q, ram_feedback_d;
    logic                busy_q, busy_d;
    logic [BANKS-1:0]    ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    act_t                ram_din_q [BANKS];
    act_t                ram_din_d [BANKS];
    act_t                shadow_q [DSP_NO];
    logic                load;
    logic [CH_W-1:0]     ch_base;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case can leave a value held and infer a latch.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        pix_d          = pix_q;
        overrun_d      = overrun_q;
        ram_feedback_d = 1'b0;
        load           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.sample_i) begin
                    load    = 1'b1;
                    beat_d  = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    pix_d  = pix_q + 1'b1;
                    beat_d = '0;
                    if (pix_q == PIX_W'(NPIX - 1)) begin
                        state_d        = DONE;
                        ram_feedback_d = 1'b1;
                    end else if (bus.sample_i) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    beat_d = beat_q + 1'b1;
                    // A sample mid-drain is lost; the drain itself carries on.
                    if (bus.sample_i) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            DONE: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered, so they are computed from the next-cycle beat/pix.
    always_comb begin
        busy_d     = (state_d == WRITE);
        ram_we_d   = {BANKS{busy_d}};
        ch_base    = CH_W'(beat_d) * CH_W'(BANKS);
        ram_addr_d = busy_d ? (ADDR_W'(beat_d) * ADDR_W'(NPIX) + ADDR_W'(pix_d)) : '0;
        for (int b = 0; b < BANKS; b++) begin
            ram_din_d[b] = '0;
            if (busy_d) begin
                ram_din_d[b] = load ? bus.ofm_i[b] : shadow_q[ch_base + CH_W'(b)];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            pix_q          <= '0;
            overrun_q      <= 1'b0;
            ram_feedback_q <= 1'b0;
            busy_q         <= 1'b0;
            ram_we_q       <= '0;
            ram_addr_q     <= '0;
            for (int b = 0; b < BANKS; b++) begin
                ram_din_q[b] <= '0;
            end
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            pix_q          <= pix_d;
            overrun_q      <= overrun_d;
            ram_feedback_q <= ram_feedback_d;
            busy_q         <= busy_d;
            ram_we_q       <= ram_we_d;
            ram_addr_q     <= ram_addr_d;
            ram_din_q      <= ram_din_d;
        end
    end

    // NOTE: the shadow array is pure data storage and is only read after a
    // load, so it has no reset; this keeps it out of the reset tree.
    always_ff @(posedge clk) begin
        if (load) begin
            shadow_q <= bus.ofm_i;
        end
    end

    assign bus.ram_we       = ram_we_q;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_din      = ram_din_q;
    assign bus.ram_feedback = ram_feedback_q;
    assign bus.busy         = busy_q;
    assign bus.overrun_err  = overrun_q;

endmodule

// File: tb/tb_fire7_expand1_ofm_writer.sv
// Self-checking bench: randomized and directed samples compared every cycle
// against a drain-window reference model of the OFM writer.
module tb_fire7_expand1_ofm_writer;
    import fire7_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fire7_expand1_ofm_writer_if bus ();

    fire7_expand1_ofm_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: at most one pixel drain window is open at a time.
    bit   m_drain;
    int   m_start;
    int   m_pix;
    int   m_accepted;
    act_t m_data [DSP_NO];
    bit   m_ovr;
    int   m_fb_cycle;
    bit   m_in_rst;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_drain    = 1'b0;
        m_start    = 0;
        m_pix      = 0;
        m_accepted = 0;
        m_ovr      = 1'b0;
        m_fb_cycle = -1;
    endfunction

    // Sample seen in cycle t: dropped mid-window, accepted otherwise unless the layer is full.
    function automatic void model_sample(input int t);
        bit active;
        active = m_drain && (t >= m_start + 1) && (t <= m_start + BEATS);
        if (active && t != m_start + BEATS) begin
            m_ovr = 1'b1;
        end else if (m_accepted < NPIX) begin
            m_drain  = 1'b1;
            m_start  = t;
            m_pix    = m_accepted;
            m_data   = bus.ofm_i;
            m_accepted++;
            if (m_pix == NPIX - 1) m_fb_cycle = t + BEATS + 1;
        end
    endfunction

    function automatic logic [63:0] pack_din();
        logic [63:0] v;
        v = '0;
        for (int b = 0; b < BANKS; b++) v = {v[47:0], bus.ram_din[b]};
        return v;
    endfunction

    task automatic compare_cycle(input int c);
        bit          exp_busy;
        int          k;
        logic [63:0] exp_din;
        exp_busy = m_drain && (c >= m_start + 1) && (c <= m_start + BEATS);
        check("busy", 64'(bus.busy), 64'(exp_busy));
        check("ram_we", 64'(bus.ram_we), exp_busy ? 64'hF : 64'h0);
        check("ram_feedback", 64'(bus.ram_feedback), 64'(c == m_fb_cycle));
        check("overrun_err", 64'(bus.overrun_err), 64'(m_ovr));
        if (exp_busy) begin
            k = c - m_start - 1;
            exp_din = '0;
            for (int b = 0; b < BANKS; b++) exp_din = {exp_din[47:0], m_data[k * BANKS + b]};
            check("ram_addr", 64'(bus.ram_addr), 64'(k * NPIX + m_pix));
            check("ram_din", pack_din(), exp_din);
        end else if (m_in_rst || (m_fb_cycle >= 0 && c >= m_fb_cycle)) begin
            check("quiet_addr", 64'(bus.ram_addr), 64'h0);
            check("quiet_din", pack_din(), 64'h0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst && bus.sample_i) model_sample(cyc);
        m_in_rst = !rst;
        #1;
        cyc++;
        compare_cycle(cyc);
    endtask

    task automatic idle(input int n);
        bus.sample_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send();
        bus.sample_i = 1'b1;
        tick();
        bus.sample_i = 1'b0;
    endtask

    task automatic set_ramp(input int base);
        for (int c = 0; c < DSP_NO; c++) bus.ofm_i[c] = act_t'(base + c);
    endtask

    task automatic set_const(input int v);
        for (int c = 0; c < DSP_NO; c++) bus.ofm_i[c] = act_t'(v);
    endtask

    task automatic set_random();
        for (int c = 0; c < DSP_NO; c++) bus.ofm_i[c] = act_t'($urandom);
    endtask

    // Asynchronous assertion between clock edges, held for three cycles.
    task automatic apply_reset();
        #2;
        rst = 1'b0;
        model_reset();
        m_in_rst = 1'b1;
        #1;
        check("async_rst_we", 64'(bus.ram_we), 64'h0);
        check("async_rst_busy", 64'(bus.busy), 64'h0);
        idle(3);
        rst = 1'b1;
        idle(2);
    endtask

    initial begin
        bus.sample_i = 1'b0;
        set_const(0);
        model_reset();
        m_in_rst = 1'b1;

        // Reset with sample pulses that must be ignored.
        repeat (3) begin
            bus.sample_i = 1'b1;
            set_random();
            tick();
        end
        bus.sample_i = 1'b0;
        rst = 1'b1;
        idle(3);

        // Single pixel, ramp data.
        set_ramp(1);
        send();
        check("px0_beat0_addr", 64'(bus.ram_addr), 64'd0);
        check("px0_beat0_din", pack_din(), 64'h0001_0002_0003_0004);
        idle(47);
        check("px0_beat47_addr", 64'(bus.ram_addr), 64'd12032);
        check("px0_beat47_din", pack_din(), 64'h00BD_00BE_00BF_00C0);
        idle(1);
        check("px0_after_we", 64'(bus.ram_we), 64'h0);
        check("px0_after_busy", 64'(bus.busy), 64'h0);
        idle(5);

        // Back-to-back: second sample on beat 47.
        apply_reset();
        set_ramp(1);
        send();
        idle(47);
        set_ramp(1000);
        send();
        check("b2b_addr", 64'(bus.ram_addr), 64'd1);
        check("b2b_din", pack_din(), 64'h03E8_03E9_03EA_03EB);
        check("b2b_busy", 64'(bus.busy), 64'h1);
        check("b2b_overrun", 64'(bus.overrun_err), 64'h0);
        idle(55);

        // Overrun: second sample on beat 10 is dropped.
        apply_reset();
        set_random();
        send();
        idle(10);
        set_random();
        send();
        check("ovr_flag", 64'(bus.overrun_err), 64'h1);
        idle(60);
        set_random();
        send();
        check("ovr_next_pix", 64'(bus.ram_addr), 64'd1);
        idle(55);

        // Random spacing and data: legal, back-to-back and overrun cadences.
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            set_random();
            send();
            idle($urandom_range(40, 70));
        end

        // Full layer at the producer cadence.
        apply_reset();
        for (int p = 0; p < NPIX; p++) begin
            set_const(p);
            send();
            if (p < NPIX - 1) idle(64);
        end
        idle(47);
        check("last_beat_addr", 64'(bus.ram_addr), 64'd12287);
        idle(1);
        check("feedback_pulse", 64'(bus.ram_feedback), 64'h1);
        idle(1);
        check("feedback_single", 64'(bus.ram_feedback), 64'h0);
        set_random();
        send();
        idle(60);
        check("done_no_overrun", 64'(bus.overrun_err), 64'h0);

        // Reset in the middle of pixel 5, beat 20.
        apply_reset();
        for (int p = 0; p < 5; p++) begin
            set_random();
            send();
            idle(49);
        end
        set_random();
        send();
        idle(20);
        check("mid_drain_we", 64'(bus.ram_we), 64'hF);
        apply_reset();
        set_random();
        send();
        check("post_rst_addr", 64'(bus.ram_addr), 64'd0);
        check("post_rst_we", 64'(bus.ram_we), 64'hF);
        idle(55);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fire7_expand1_ofm_writer.md
Name: fire7_expand1_ofm_writer

Overview:
- Downstream of the fire7 expand1 MAC array.
- Captures the 192-channel post-ReLU output vector on each sample pulse and drains it into a banked feature-map RAM, BANKS words per cycle.
- Returns a one-cycle ram_feedback pulse once all WOUT*WOUT pixels are stored; the expand1 layer latches this pulse to release its finish flag.

Parameters:
- WIDTH, 16, bits per activation word
- DSP_NO, 192, channels per output pixel (must be a multiple of BANKS)
- WOUT, 16, output feature-map side; pixel count NPIX = WOUT*WOUT = 256
- BANKS, 4, parallel RAM banks; BEATS = DSP_NO/BANKS = 48 write cycles per pixel
- ADDR_W, $clog2(BEATS*NPIX) = 14, per-bank address width

Ports:
- clk, input, 1, clock
- rst, input, 1, asynchronous active-low reset
- sample_i, input, 1, one-cycle pulse: ofm_i is valid this cycle
- ofm_i, input, WIDTH x DSP_NO (unpacked array), channel outputs
- ram_we, output, BANKS, per-bank write enable
- ram_addr, output, ADDR_W, shared address for all banks
- ram_din, output, WIDTH x BANKS (unpacked array), per-bank write data
- ram_feedback, output, 1, one-cycle pulse: layer fully written
- busy, output, 1, drain in progress
- overrun_err, output, 1, sticky: a sample was dropped

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, state IDLE, beat=0, pix=0, shadow registers need not be cleared. Reset mid-drain aborts the drain; no further writes.
- Reset release: operation resumes from IDLE with pix=0.
- States and transitions:
  - IDLE: sample_i -> shadow <= ofm_i, beat <= 0, go WRITE.
  - WRITE: one beat per cycle. Bank b gets shadow[beat*BANKS+b] at ram_addr = beat*NPIX + pix. All ram_we bits are 1.
  - WRITE on beat == BEATS-1: pix increments.
    - If pix was NPIX-1: go DONE.
    - Else if sample_i is high this cycle: reload shadow, beat <= 0, stay WRITE (back-to-back, no bubble).
    - Else: go IDLE.
  - DONE: ram_feedback high for exactly one cycle on entry. Then state holds with all outputs low except overrun_err. Samples in DONE are ignored and do not set overrun_err. Only reset leaves DONE.
- Timing, for sample_i high in cycle t (accepted):
  - ram_we/ram_addr/ram_din are registered; beat 0 appears in cycle t+1 and beat k in cycle t+1+k.
  - busy = 1 in cycles t+1..t+BEATS.
  - For the final pixel, ram_feedback = 1 in cycle t+BEATS+1.
- Overrun: sample_i high in WRITE with beat != BEATS-1:
  - The sample is dropped, overrun_err <= 1 (sticky until reset).
  - The current drain continues unchanged and pix is not advanced for the dropped sample.
- Upstream cadence: the producer samples every CHIN+1 = 65 cycles, which is at least BEATS, so no overrun occurs in normal operation.
- Width rule:
  - Data passes through unmodified; no saturation or arithmetic.
  - Address arithmetic is unsigned ADDR_W; maximum address is 47*256 + 255 = 12287.
- Elaboration assertion: DSP_NO % BANKS == 0.

Decomposition:
- Shared package fire7_pkg holds:
  - constants WIDTH, DSP_NO, WOUT, BANKS, BEATS, NPIX, ADDR_W
  - typedef act_t = logic [WIDTH-1:0]
  - enum wr_state_t {IDLE, WRITE, DONE}
- No sub-module. A single module with the shadow register array, beat/pix counters and the 3-state FSM is the natural size.

Test Plan:
- Reset values: hold rst low 3 cycles, pulse sample_i during reset. Required: all outputs 0, no ram_we. Release reset: still idle.
- Single pixel: ofm_i[c] = c+1, one sample at t. Required:
  - cycle t+1: ram_we = 4'b1111, ram_addr = 0, ram_din = {1,2,3,4}
  - cycle t+48: ram_addr = 47*256 = 12032, ram_din = {189,190,191,192}
  - cycle t+49: ram_we = 0, busy = 0
- Back-to-back: second sample exactly on beat 47 with ofm_i[c] = 1000+c. Required: next cycle ram_addr = 1 (beat 0, pix 1), ram_din = {1000..1003}, no idle gap, overrun_err = 0.
- Overrun: second sample on beat 10. Required:
  - overrun_err = 1 from the next cycle onward.
  - The first pixel completes through beat 47 with original data.
  - The following legal sample writes pix 1 (not pix 2).
- Full layer: 256 samples at 65-cycle spacing, with data = pixel index in all channels. Required:
  - ram_feedback pulses once, one cycle after the final beat (addr 12287).
  - A subsequent sample produces no writes and overrun_err stays 0.
- Reset mid-drain: assert rst at beat 20 of pix 5. Required:
  - ram_we drops immediately (asynchronously).
  - After release, the next sample writes pix 0, beat 0 at ram_addr = 0.
